// File: rtl/md5_block_padder.sv
// md5_block_padder: packs a byte stream into 512-bit blocks with Merkle-Damgard padding.
// Define MD5_PADDER_STATS_EN to add msg_count/blk_count outputs.
module md5_block_padder #(
  parameter int IN_W           = 32,
  parameter bit LEN_BIG_ENDIAN = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_W-1:0]           in_data,
  input  logic                      in_last,
  input  logic [$clog2(IN_W/8):0]   in_bytes,
  output logic                      blk_valid,
  input  logic                      blk_ready,
  output logic [511:0]              blk_data,
  output logic                      blk_first,
  output logic                      blk_last,
  output logic                      err_len
`ifdef MD5_PADDER_STATS_EN
  ,
  output logic [31:0]               msg_count,
  output logic [31:0]               blk_count
`endif
);
  localparam int BPB = IN_W / 8;
  typedef enum logic [1:0] {ACC, EMIT, PAD, EXTRA} state_t;
  state_t state, state_nx;
  logic [511:0] acc, merged, marker, len_blk;
  logic [IN_W-1:0] beat;
  logic [6:0] fill, n, fill_f;
  logic [63:0] count, len;
  // block queued behind the current one: 0 none, 1 marker+length, 2 length only
  logic [1:0] tail;
  logic first_pend, take, hs;
  assign in_ready = (state == ACC);
  always_comb begin
    beat = '0;
    len = '0;
    take = in_valid && (state == ACC);
    hs = blk_valid && blk_ready;
    n = (!in_last || 32'(in_bytes) > BPB) ? 7'(BPB) : 7'(in_bytes);
    for (int j = 0; j < BPB; j++) beat[8*j +: 8] = (j < 32'(n)) ? in_data[8*j +: 8] : 8'h00;
    fill_f = fill + n;
    merged = acc | (512'(beat) << {fill, 3'b000});
    marker = 512'h80 << {fill, 3'b000};
    for (int i = 0; i < 8; i++) len[8*i +: 8] = LEN_BIG_ENDIAN ? count[8*(7-i) +: 8] : count[8*i +: 8];
    len_blk = {len, 448'b0};
    state_nx = state;
    case (state)
      ACC:     state_nx = !take ? ACC : in_last ? PAD : (fill_f == 7'd64) ? EMIT : ACC;
      PAD:     state_nx = EMIT;
      EMIT:    state_nx = !hs ? EMIT : (tail != 2'd0) ? EXTRA : ACC;
      default: state_nx = hs ? ACC : EXTRA;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ACC;
      acc <= '0;
      fill <= '0;
      count <= '0;
      tail <= '0;
      first_pend <= 1'b1;
      blk_valid <= 1'b0;
      blk_data <= '0;
      blk_first <= 1'b0;
      blk_last <= 1'b0;
      err_len <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        count <= count + (64'(n) << 3);
        if (in_last && 32'(in_bytes) > BPB) err_len <= 1'b1;
        if (!in_last && fill_f == 7'd64) begin
          blk_data <= merged;
          blk_valid <= 1'b1;
          blk_first <= first_pend;
          blk_last <= 1'b0;
          tail <= 2'd0;
          acc <= '0;
          fill <= '0;
        end else begin
          acc <= merged;
          fill <= fill_f;
        end
      end
      if (state == PAD) begin
        blk_valid <= 1'b1;
        blk_first <= first_pend;
        acc <= '0;
        fill <= '0;
        blk_data <= (fill == 7'd64) ? acc : (fill <= 7'd55) ? (acc | marker | len_blk) : (acc | marker);
        blk_last <= (fill <= 7'd55);
        tail <= (fill == 7'd64) ? 2'd1 : (fill <= 7'd55) ? 2'd0 : 2'd2;
      end
      if (hs) begin
        first_pend <= blk_last;
        if (blk_last) count <= '0;
        if (state == EMIT && tail != 2'd0) begin
          blk_data <= ((tail == 2'd1) ? 512'h80 : 512'h0) | len_blk;
          blk_first <= 1'b0;
          blk_last <= 1'b1;
          tail <= 2'd0;
        end else begin
          blk_valid <= 1'b0;
        end
      end
    end
  end
`ifdef MD5_PADDER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_count <= '0;
      blk_count <= '0;
    end else if (hs) begin
      blk_count <= blk_count + 32'd1;
      if (blk_last) msg_count <= msg_count + 32'd1;
    end
  end
`endif
endmodule
